// File: rtl/serie_paralelo_pkg.sv
// Shared types and constants for the serial-to-parallel deserializer.
// Holds the FSM state type, the default word length and the bit-counter width helper.
package serie_paralelo_pkg;

  localparam int WIDTH_DEF = 6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int idx_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serie_paralelo_if.sv
// Stream-in / word-out bundle of the deserializer.
// The master drives the serial stream and the accept strobe; the slave returns words and flags.
interface serie_paralelo_if
  import serie_paralelo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             ena_in;
  logic             in;
  logic             ready_in;
  logic [WIDTH-1:0] out;
  logic             ena_out;
  logic             sync_err;
  logic             ovf;

  modport master (
    output ena_in, in, ready_in,
    input  out, ena_out, sync_err, ovf
  );

  modport slave (
    input  ena_in, in, ready_in,
    output out, ena_out, sync_err, ovf
  );

endinterface

// File: rtl/serie_paralelo_fifo2.sv
// Two-entry synchronous FIFO; a push and a pop on the same edge are both honoured,
// even when full, because the write lands in the slot being vacated.
module fifo2 #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_rd_ptr;
  logic [1:0]       r_cnt;
  logic             w_do_push;
  logic             w_do_pop;
  logic             w_wr_ptr;

  assign o_full    = (r_cnt == 2'd2);
  assign o_empty   = (r_cnt == 2'd0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign w_wr_ptr  = r_rd_ptr ^ r_cnt[0];
  assign o_data    = r_mem[r_rd_ptr];

  // Storage, read pointer and occupancy
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[w_wr_ptr] <= i_data;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/serie_paralelo.sv
// Serial-to-parallel deserializer: LSB-first stream framed by ena_in, words delivered
// through a 2-entry buffer with valid/ready, plus framing-slip and overflow flags.
module serie_paralelo
  import serie_paralelo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic           clk,
  input logic           clr_n,
  serie_paralelo_if.slave bus
);

  localparam int           IW       = idx_width(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    w_idx_nxt;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_sreg_nxt;
  logic             w_push;
  logic             w_slip;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [WIDTH-1:0] w_head;
  logic             r_sync_err;
  logic             r_ovf;

  // Framing FSM: bit placement, word completion and slip detection
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_sreg_nxt  = r_sreg;
    w_push      = 1'b0;
    w_slip      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.ena_in) begin
          w_sreg_nxt  = {{(WIDTH-1){1'b0}}, bus.in};
          w_idx_nxt   = IW'(1);
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (bus.ena_in && (r_idx != '0)) begin
          // Restart framing on the new word; the partial word is thrown away
          w_sreg_nxt = {{(WIDTH-1){1'b0}}, bus.in};
          w_idx_nxt  = IW'(1);
          w_slip     = 1'b1;
        end else begin
          w_sreg_nxt[r_idx] = bus.in;
          if (r_idx == LAST_IDX) begin
            w_push    = 1'b1;
            w_idx_nxt = '0;
          end else begin
            w_idx_nxt = r_idx + IW'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state, bit counter, shift register and flags
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_sreg     <= '0;
      r_sync_err <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_sreg     <= w_sreg_nxt;
      r_sync_err <= w_slip;
      r_ovf      <= r_ovf | (w_push & w_full & ~w_pop);
    end
  end

  assign w_pop = ~w_empty & bus.ready_in;

  fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .clk     (clk),
    .clr_n   (clr_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_sreg_nxt),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.out      = w_head;
  assign bus.ena_out  = ~w_empty;
  assign bus.sync_err = r_sync_err;
  assign bus.ovf      = r_ovf;

endmodule

// File: doc/serie_paralelo.md
# serie_paralelo

Serial-to-parallel deserializer placed directly downstream of the team's parallel-to-serial stage. Consumes the 1-bit LSB-first stream and its start strobe, reassembles WIDTH-bit words, and presents them through a 2-entry buffer with a valid/ready handshake. Detects framing slips and buffer overflow and reports them as flags.

## Interface
- WIDTH, 6, word length in bits; legal range 2..16.
- clk  in  1  single clock; all logic on the rising edge.
- clr_n  in  1  asynchronous, active-low reset.
- ena_in  in  1  high on the cycle that carries bit 0 of a word.
- in  in  1  serial data bit, LSB first.
- out  out  WIDTH  word at the buffer head; valid only while ena_out=1.
- ena_out  out  1  word available (valid).
- ready_in  in  1  consumer accepts the head word when ena_out & ready_in.
- sync_err  out  1  one-cycle pulse on a framing slip.
- ovf  out  1  sticky; set when a completed word is dropped. Cleared only by clr_n.

## Operation
- FSM states: IDLE, RUN.
- IDLE: ignore in until ena_in=1. On that edge, capture in as bit 0, set bit counter idx=1, go to RUN.
- RUN: one bit per cycle, streamed continuously. Capture in into sreg[idx].
  - If idx=WIDTH-1: assemble the word, push it to the buffer, and set idx=0.
  - Otherwise increment idx.
  - Back-to-back words need no further ena_in.
- ena_in in RUN with idx=0: normal; no action.
- ena_in in RUN with idx≠0 (slip):
  - Discard the partial word.
  - Capture in as bit 0 and set idx=1.
  - Pulse sync_err for one cycle.
- Buffer: 2-entry FIFO. Push and pop on the same edge are both honoured, including when the buffer is full.
- Push while full with no pop: word dropped, ovf←1, buffer contents unchanged.
- ena_out = buffer not empty. out = head entry, driven directly from the registered storage.
- Asynchronous reset, mid-word or mid-handshake:
  - FSM→IDLE, idx=0, sreg=0, buffer emptied.
  - out=0, ena_out=0, sync_err=0, ovf=0.
  - After release, the first ena_in starts a fresh word.

## Timing
- Last bit (bit WIDTH-1) sampled at edge k → ena_out=1 and out valid from edge k (visible in cycle k+1). Latency is 1 cycle after the last bit.
- With ready_in held high, each word stays at the head for exactly 1 cycle. Sustained throughput is 1 word per WIDTH cycles with no loss.
- With ready_in low, the buffer holds 2 words. The 3rd completed word is dropped → ovf set at edge k of that word's last bit.
- sync_err is registered: high in the cycle after the slipping ena_in was sampled.
- out and ena_out are unchanged while ena_out=1 and ready_in=0; the head is stable until accepted.

## Structure
- Shared package serie_paralelo_pkg holds:
  - the FSM state typedef (IDLE, RUN);
  - the WIDTH default constant;
  - the bit-counter width function, clog2(WIDTH).
- One sub-module: fifo2, a parameterised 2-entry synchronous FIFO with push/pop/full/empty and the same clock and reset.
- Top level contains the FSM, bit counter, shift register, and flag logic.

## Test plan
- Reset and single word:
  - Release clr_n, hold ready_in=1.
  - ena_in=1 with bits 1,0,1,1,0,1 on consecutive cycles.
  - Expect out=6'h2D with ena_out high for exactly 1 cycle, 1 cycle after the last bit; sync_err=0, ovf=0.
- Continuous stream:
  - One ena_in, then 4 back-to-back words: 6'h00, 6'h3F, 6'h15, 6'h2A.
  - Expect 4 ena_out pulses spaced 6 cycles apart with those values in order.
- Backpressure and overflow:
  - ready_in=0, 3 words 6'h01, 6'h02, 6'h03.
  - Expect ena_out=1 with out=6'h01 held, and ovf=1 after the 3rd word.
  - Then ready_in=1: expect 6'h01 then 6'h02, no 6'h03.
- Framing slip:
  - ena_in at bit 3 of a word, followed by a full word 6'h2D.
  - Expect a sync_err pulse, no output for the partial word, then out=6'h2D.
- Reset mid-operation:
  - Assert clr_n=0 asynchronously, mid-clock-cycle, with 1 word buffered and 3 bits received.
  - Expect ena_out=0, out=0, ovf=0 immediately.
  - After release, the next framed word 6'h12 arrives intact.
- Simultaneous push and pop while full:
  - Buffer full, ready_in=1 on the edge a new word completes.
  - Expect no drop, ovf=0, and the new word delivered third.
